// File: rtl/draw_rect_anim.sv
// draw_rect_anim: pixel stage that sits behind the VGA timing generator.
// Re-emits the timing signals one pclk later and overlays a solid rectangle
// on the background stream. The rectangle bounces inside the active area and
// moves once per frame, at the rising edge of vertical blank.
// Optional build macro DRAW_RECT_PAUSE_EN adds a `pause` input. While `pause`
// is high at a frame tick, position and direction hold. Drawing is unaffected.
module draw_rect_anim #(
    parameter int unsigned RECT_W     = 48,
    parameter int unsigned RECT_H     = 64,
    parameter logic [11:0] RECT_COLOR = 12'hF00,
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned STEP       = 1,
    parameter int unsigned X0         = 100,
    parameter int unsigned Y0         = 100
) (
    input  logic        pclk,
    input  logic        rst,
`ifdef DRAW_RECT_PAUSE_EN
    input  logic        pause,
`endif
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos
);

    localparam int unsigned XMAX = H_ACTIVE - RECT_W;
    localparam int unsigned YMAX = V_ACTIVE - RECT_H;

    localparam logic [10:0] XMAX11   = 11'(XMAX);
    localparam logic [10:0] YMAX11   = 11'(YMAX);
    localparam logic [11:0] RECT_W12 = 12'(RECT_W);
    localparam logic [11:0] RECT_H12 = 12'(RECT_H);
    localparam logic [11:0] STEP12   = 12'(STEP);

    // Illegal configurations stop elaboration.
    if (X0 > XMAX) begin : g_bad_x0
        $fatal(1, "draw_rect_anim: X0 must not exceed H_ACTIVE-RECT_W");
    end
    if (Y0 > YMAX) begin : g_bad_y0
        $fatal(1, "draw_rect_anim: Y0 must not exceed V_ACTIVE-RECT_H");
    end
    if (STEP < 1 || STEP > 15) begin : g_bad_step
        $fatal(1, "draw_rect_anim: STEP must be in 1..15");
    end

    // Forward means right on X and down on Y.
    typedef enum logic {
        DIR_FWD  = 1'b0,
        DIR_BACK = 1'b1
    } dir_t;

    // Bounce one axis by STEP. The result is {next_dir, next_pos}.
    // The comparison is done at 12 bits so that pos+STEP cannot wrap.
    function automatic logic [11:0] bounce(input logic [10:0] pos,
                                           input logic        dir,
                                           input logic [10:0] lim);
        logic [11:0] p;
        p = {1'b0, pos};
        if (dir == DIR_FWD) begin
            if (p + STEP12 >= {1'b0, lim}) return {DIR_BACK, lim};
            else                           return {DIR_FWD, 11'(p + STEP12)};
        end else begin
            if (p <= STEP12) return {DIR_FWD, 11'd0};
            else             return {DIR_BACK, 11'(p - STEP12)};
        end
    endfunction

    logic [10:0] hcount_q, vcount_q;
    logic        hsync_q, hblnk_q, vsync_q, vblnk_q;
    logic [11:0] rgb_q, rgb_d;
    logic [10:0] x_pos_q, y_pos_q;
    dir_t        dir_x_q, dir_y_q;
    logic        armed_q;
    logic        frame_tick, move;
    logic [11:0] mv_x_d, mv_y_d;
    logic        in_x, in_y;

    // Rectangle hit test against the registered position (12-bit, unsigned).
    assign in_x = ({1'b0, hcount_in} >= {1'b0, x_pos_q}) &&
                  ({1'b0, hcount_in} <  {1'b0, x_pos_q} + RECT_W12);
    assign in_y = ({1'b0, vcount_in} >= {1'b0, y_pos_q}) &&
                  ({1'b0, vcount_in} <  {1'b0, y_pos_q} + RECT_H12);

    // Pixel colour selection: blanking wins, then the rectangle, then background.
    always_comb begin
        rgb_d = rgb_in;
        if (hblnk_in | vblnk_in)
            rgb_d = 12'h000;
        else if (in_x && in_y)
            rgb_d = RECT_COLOR;
    end

    // Timing re-emit and composed pixel, one register stage.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_q <= '0;
            hsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vcount_q <= '0;
            vsync_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= '0;
        end else begin
            hcount_q <= hcount_in;
            hsync_q  <= hsync_in;
            hblnk_q  <= hblnk_in;
            vcount_q <= vcount_in;
            vsync_q  <= vsync_in;
            vblnk_q  <= vblnk_in;
            rgb_q    <= rgb_d;
        end
    end

    // vblnk_q doubles as the delayed vblank used for edge detection. armed_q
    // blocks a tick until vblank has been seen low after reset, so a vblank
    // that is already high at release does not count as a new frame.
    assign frame_tick = vblnk_in & ~vblnk_q & armed_q;
`ifdef DRAW_RECT_PAUSE_EN
    assign move = frame_tick & ~pause;
`else
    assign move = frame_tick;
`endif

    // Track whether vblank has been low since reset.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) armed_q <= 1'b0;
        else if (!vblnk_in) armed_q <= 1'b1;
    end

    assign mv_x_d = bounce(x_pos_q, dir_x_q, XMAX11);
    assign mv_y_d = bounce(y_pos_q, dir_y_q, YMAX11);

    // Position and direction update once per frame. The axes are independent.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            x_pos_q <= 11'(X0);
            y_pos_q <= 11'(Y0);
            dir_x_q <= DIR_FWD;
            dir_y_q <= DIR_FWD;
        end else if (move) begin
            x_pos_q <= mv_x_d[10:0];
            dir_x_q <= dir_t'(mv_x_d[11]);
            y_pos_q <= mv_y_d[10:0];
            dir_y_q <= dir_t'(mv_y_d[11]);
        end
    end

    assign hcount_out = hcount_q;
    assign hsync_out  = hsync_q;
    assign hblnk_out  = hblnk_q;
    assign vcount_out = vcount_q;
    assign vsync_out  = vsync_q;
    assign vblnk_out  = vblnk_q;
    assign rgb_out    = rgb_q;
    assign x_pos      = x_pos_q;
    assign y_pos      = y_pos_q;

endmodule

// File: tb/tb_draw_rect_anim.sv
// Testbench for draw_rect_anim: default instance plus a corner-start instance.
module tb_draw_rect_anim;

    localparam int XMAX = 752;
    localparam int YMAX = 536;
    localparam int STEP = 1;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0;

    logic [10:0] hcount_out, vcount_out, x_pos, y_pos;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    logic [10:0] hcount_out_c, vcount_out_c, x_pos_c, y_pos_c;
    logic        hsync_out_c, hblnk_out_c, vsync_out_c, vblnk_out_c;
    logic [11:0] rgb_out_c;

    int errors = 0;
    int checks = 0;

    // Reference model state, index 0 = default instance, 1 = corner instance.
    int x0s[2] = '{100, 751};
    int y0s[2] = '{100, 535};
    int mx[2], my[2], mdx[2], mdy[2];
    bit prev_vb;

    always #5 pclk = ~pclk;

    draw_rect_anim dut (
        .pclk(pclk), .rst(rst),
`ifdef DRAW_RECT_PAUSE_EN
        .pause(pause),
`endif
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out), .x_pos(x_pos), .y_pos(y_pos)
    );

    draw_rect_anim #(.X0(751), .Y0(535)) dut_c (
        .pclk(pclk), .rst(rst),
`ifdef DRAW_RECT_PAUSE_EN
        .pause(pause),
`endif
        .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in),
        .hcount_out(hcount_out_c), .hsync_out(hsync_out_c), .hblnk_out(hblnk_out_c),
        .vcount_out(vcount_out_c), .vsync_out(vsync_out_c), .vblnk_out(vblnk_out_c),
        .rgb_out(rgb_out_c), .x_pos(x_pos_c), .y_pos(y_pos_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Triangle-wave motion: move, then clamp and turn around at either wall.
    function automatic void adv(inout int p, inout int d, input int lim);
        p = p + d * STEP;
        if (p >= lim) begin p = lim; d = -1; end
        else if (p <= 0) begin p = 0; d = 1; end
    endfunction

    function automatic logic [11:0] exp_rgb(input int i, input int hc, input int vc,
                                            input bit hb, input bit vb, input logic [11:0] rgb);
        if (hb || vb) return 12'h000;
        if (hc >= mx[i] && hc < mx[i] + 48 && vc >= my[i] && vc < my[i] + 64) return 12'hF00;
        return rgb;
    endfunction

    // Apply one pixel, let one pclk pass, then compare everything.
    task automatic step(input int hc, input int vc, input bit hs, input bit vs,
                        input bit hb, input bit vb, input logic [11:0] rgb);
        logic [11:0] e0, e1;
        bit tick;
        hcount_in = 11'(hc); vcount_in = 11'(vc);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        e0 = exp_rgb(0, hc, vc, hb, vb, rgb);
        e1 = exp_rgb(1, hc, vc, hb, vb, rgb);
        tick = vb && !prev_vb && !pause;
        prev_vb = vb;
        if (tick) begin
            for (int i = 0; i < 2; i++) begin
                adv(mx[i], mdx[i], XMAX);
                adv(my[i], mdy[i], YMAX);
            end
        end
        @(posedge pclk); #1;
        chk("timing", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out},
                      {11'(hc), hs, hb, 11'(vc), vs, vb});
        chk("rgb", rgb_out, e0);
        chk("rgb_c", rgb_out_c, e1);
        chk("x", x_pos, mx[0]);
        chk("y", y_pos, my[0]);
        chk("x_c", x_pos_c, mx[1]);
        chk("y_c", y_pos_c, my[1]);
    endtask

    // One compressed frame: an active pixel, then the vblank rising edge.
    task automatic frame();
        int h;
        h = $urandom_range(0, 1055);
        step(h, $urandom_range(0, 599), 1'($urandom), 1'b0, h >= 800, 1'b0, 12'($urandom));
        step($urandom_range(0, 1055), $urandom_range(600, 627), 1'($urandom), 1'($urandom),
             1'($urandom), 1'b1, 12'($urandom));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rgb", rgb_out, 12'h000);
        chk("rst_timing", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out}, 0);
        chk("rst_x", x_pos, 100);
        chk("rst_y", y_pos, 100);
        chk("rst_x_c", x_pos_c, 751);
        chk("rst_y_c", y_pos_c, 535);
        for (int i = 0; i < 2; i++) begin
            mx[i] = x0s[i]; my[i] = y0s[i]; mdx[i] = 1; mdy[i] = 1;
        end
        prev_vb = 1'b1;
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int hcs[4];
        int vcs[4];
        int h;
        int saved_x;
        hcs = '{99, 100, 147, 148};
        vcs = '{99, 100, 163, 164};

        #2;
        do_reset();

        // Rectangle edges at the reset position.
        foreach (hcs[a]) foreach (vcs[b])
            step(hcs[a], vcs[b], 1'b0, 1'b0, 1'b0, 1'b0, 12'($urandom));
        step(120, 130, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
        chk("inside_const", rgb_out, 12'hF00);
        step(148, 130, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0);
        chk("right_of_rect", rgb_out, 12'h0F0);
        step(120, 130, 1'b0, 1'b0, 1'b1, 1'b0, 12'h0F0);
        chk("hblank_black", rgb_out, 12'h000);

        // Random active-area pixels, no frame ticks.
        for (int n = 0; n < 300; n++) begin
            h = $urandom_range(0, 1055);
            step(h, $urandom_range(0, 599), 1'($urandom), 1'($urandom),
                 (h >= 800) || ($urandom_range(0, 7) == 0), 1'b0, 12'($urandom));
        end

        // Fully random timing, including random vblank toggling.
        for (int n = 0; n < 300; n++)
            step($urandom_range(0, 2047), $urandom_range(0, 2047), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 12'($urandom));

        // Motion from reset, including wall and corner reversal.
        do_reset();
        for (int f = 1; f <= 653; f++) begin
            frame();
            if (f == 1)   begin chk("corner_x1", x_pos_c, 752); chk("corner_y1", y_pos_c, 536); end
            if (f == 2)   begin chk("corner_x2", x_pos_c, 751); chk("corner_y2", y_pos_c, 535); end
            if (f == 436) chk("y_wall", y_pos, 536);
            if (f == 437) chk("y_back", y_pos, 535);
            if (f == 652) chk("x_wall", x_pos, 752);
            if (f == 653) chk("x_back", x_pos, 751);
        end

        // Reset in the middle of a frame, then release with vblank already high.
        do_reset();
        for (int f = 0; f < 400; f++) frame();
        chk("x_at_500", x_pos, 500);
        step(400, 300, 1'b0, 1'b0, 1'b0, 1'b0, 12'h5A5);
        chk("mid_rgb", rgb_out, 12'h5A5);
        do_reset();
        for (int n = 0; n < 5; n++)
            step(500, 610, 1'b0, 1'b1, 1'b0, 1'b1, 12'($urandom));
        chk("no_tick_on_release", x_pos, 100);
        step(10, 10, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123);
        step(10, 600, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123);
        chk("first_tick", x_pos, 101);

`ifdef DRAW_RECT_PAUSE_EN
        pause = 1'b1;
        saved_x = mx[0];
        for (int f = 0; f < 10; f++) frame();
        chk("pause_hold", x_pos, 11'(saved_x));
        step(saved_x + 5, 120, 1'b0, 1'b0, 1'b0, 1'b0, 12'h00F);
        chk("pause_draw", rgb_out, 12'hF00);
        pause = 1'b0;
        frame();
        chk("pause_resume", x_pos, 11'(saved_x + 1));
`else
        saved_x = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_rect_anim.md
Name: draw_rect_anim

Overview:
- Pixel stage directly downstream of the VGA timing generator.
- Takes timing signals (hcount/vcount/sync/blank) plus a background RGB stream.
- Overlays a solid rectangle that bounces around the active area, moving once per frame.
- Re-emits the timing signals aligned with the new RGB; output feeds the next draw stage or the VGA output register.

Parameters:
- RECT_W, 48, rectangle width in pixels
- RECT_H, 64, rectangle height in pixels
- RECT_COLOR, 12'hF_0_0, rectangle RGB444 colour
- H_ACTIVE, 800, visible pixels per line
- V_ACTIVE, 600, visible lines per frame
- STEP, 1, pixels moved per frame on each axis (1..15)
- X0, 100, reset x position (top-left corner)
- Y0, 100, reset y position (top-left corner)

Ports:
- pclk  input  1  pixel clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- hcount_in  input  11  horizontal pixel counter from timing stage
- hsync_in  input  1  horizontal sync
- hblnk_in  input  1  horizontal blank
- vcount_in  input  11  vertical line counter
- vsync_in  input  1  vertical sync
- vblnk_in  input  1  vertical blank
- rgb_in  input  12  background pixel RGB444
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  output  11/1/1/11/1/1  inputs delayed by exactly 1 pclk
- rgb_out  output  12  composed pixel, aligned with *_out timing
- x_pos  output  11  current rectangle left edge (debug/next stage)
- y_pos  output  11  current rectangle top edge

Behaviour:
- Reset (async assert, sync-safe release): all *_out and rgb_out = 0; x_pos = X0, y_pos = Y0; dir_x = RIGHT, dir_y = DOWN; vblnk_d = 0.
- Latency: exactly 1 pclk from any input to the corresponding output. No bubbles and no stalls.
- Pixel rule, registered:
  - if hblnk_in | vblnk_in, then rgb_out = 12'h000
  - else if x_pos <= hcount_in < x_pos+RECT_W and y_pos <= vcount_in < y_pos+RECT_H, then rgb_out = RECT_COLOR
  - else rgb_out = rgb_in
- Comparisons are unsigned and done at 12 bits to avoid overflow of x_pos+RECT_W.
- Frame event: frame_tick = vblnk_in & ~vblnk_d, where vblnk_d is vblnk_in registered. Exactly one tick per frame, at the start of vertical blank.
- Position and direction registers change only on frame_tick, so the rectangle is stable across the whole active frame.
- X axis, on frame_tick; XMAX = H_ACTIVE-RECT_W:
  - RIGHT: if x_pos+STEP >= XMAX, then x_pos <= XMAX and dir_x <= LEFT; else x_pos <= x_pos+STEP.
  - LEFT: if x_pos <= STEP, then x_pos <= 0 and dir_x <= RIGHT; else x_pos <= x_pos-STEP.
- Y axis: identical rule with YMAX = V_ACTIVE-RECT_H and UP/DOWN.
- Axes are independent. A corner hit reverses both directions on the same tick.
- Edge clamping: position never leaves [0, XMAX] × [0, YMAX]. The edge value is held for exactly one frame before moving away.
- X0 > XMAX or Y0 > YMAX is illegal. Check it with an elaboration-time assertion.
- Reset mid-frame: outputs are forced to 0 immediately. After release, the first frame_tick needs a fresh vblnk rising edge; a vblnk already high at release does not tick.

Optional Feature:
- Macro: DRAW_RECT_PAUSE_EN.
- Defined:
  - adds port pause (input, 1); while pause = 1 at frame_tick, position and direction hold.
  - drawing continues normally.
  - pause has no effect on the pixel/timing path.
- Undefined: no pause port; motion on every frame_tick.

Test Plan:
- Reset then run one frame (800x600 active, 1056x628 total):
  - expect rgb_out = 12'hF00 exactly when hcount_out∈[100,147] and vcount_out∈[100,163] during active video.
  - expect rgb_out = rgb_in delayed 1 cycle elsewhere, and 0 in blanking.
- Latency: toggle hsync_in/vblnk_in with random patterns → each *_out equals its input 1 pclk later, and rgb_out timing matches.
- Motion: 652 frames from reset → x_pos = 752 and dir_x LEFT. Frame 653 → x_pos = 751. Y: 436 frames → y_pos = 536, then 535.
- Corner: X0 = 751, Y0 = 535 → after 1 tick, x_pos = 752 and y_pos = 536. After 2 ticks, x_pos = 751 and y_pos = 535 (both reversed together).
- Reset mid-frame at hcount = 400, vcount = 300 with x_pos = 500 → rgb_out = 0 within the same cycle. After release, x_pos = 100, and no move occurs until the next vblnk rising edge.
- DRAW_RECT_PAUSE_EN defined, pause = 1 for 10 frames → x_pos/y_pos constant; the rectangle is still drawn. Release → motion resumes from the held position.
